// File: rtl/formula_sweep_checker.sv
// Exhaustive input sweep for a combinational formula/Skolem-check block: drives every
// assignment on vec, tallies cycles where f_in is 0, captures the first failing assignment.
module formula_sweep_checker #(
   parameter int NUM_IN       = 19,
   parameter int CNT_W        = NUM_IN + 1,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [NUM_IN-1:0] vec,
   input  logic              f_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              aborted,
   output logic [CNT_W-1:0]  fail_count,
   output logic [NUM_IN-1:0] cex,
   output logic              cex_valid
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   localparam logic [NUM_IN-1:0] VEC_LAST = '1;
   localparam logic [NUM_IN-1:0] VEC_ONE  = {{(NUM_IN-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]        state;
   logic              fail_now;
   logic              last_vec;
   logic              stop_fail;
   logic              end_run;
   logic [CNT_W-1:0]  fc_next;

   // Counter holds at all-ones rather than wrapping back to a clean-looking zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == '1)
         return c;
      return c + CNT_ONE;
   endfunction

   always_comb begin
      fail_now  = ~f_in;
      last_vec  = (vec == VEC_LAST);
      stop_fail = STOP_ON_FAIL && fail_now;
      end_run   = abort || stop_fail || last_vec;
      fc_next   = fail_now ? sat_inc(fail_count) : fail_count;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         aborted    <= 1'b0;
         fail_count <= '0;
         cex        <= '0;
         cex_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  vec        <= '0;
                  fail_count <= '0;
                  cex        <= '0;
                  cex_valid  <= 1'b0;
                  pass       <= 1'b0;
                  aborted    <= 1'b0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               // The result of the assignment held this cycle is tallied even on abort.
               fail_count <= fc_next;
               if (fail_now && !cex_valid) begin
                  cex       <= vec;
                  cex_valid <= 1'b1;
               end
               if (end_run) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= abort;
                  pass    <= (fc_next == '0) && !abort && !stop_fail && last_vec;
                  state   <= FIN;
               end else begin
                  vec <= vec + VEC_ONE;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
